// File: rtl/stream_block_fifo.sv
// stream_block_fifo: FWFT stream FIFO that frames output into BDIM-beat blocks and SDIM-block frames
module stream_block_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int BDIM       = 16,
  parameter int SDIM       = 256,
  parameter int CNT_W      = 16
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [DATA_WIDTH-1:0]      s_axis_input_tdata,
  input  logic                       s_axis_input_tvalid,
  output logic                       s_axis_input_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_output_tdata,
  output logic                       m_axis_output_tvalid,
  input  logic                       m_axis_output_tready,
  output logic                       m_axis_output_tlast,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [CNT_W-1:0]           blocks_done,
  output logic                       frame_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int BW = (BDIM > 1) ? $clog2(BDIM) : 1;
  localparam int SW = (SDIM > 1) ? $clog2(SDIM) : 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill_nxt;
  logic [BW-1:0] beat_cnt;
  logic [SW-1:0] block_cnt;
  logic push, pop, last;
  always_comb begin
    push     = s_axis_input_tvalid && s_axis_input_tready;
    pop      = m_axis_output_tvalid && m_axis_output_tready;
    last     = beat_cnt == BW'(BDIM - 1);
    fill_nxt = fill_level + FW'(push) - FW'(pop);
  end
  assign m_axis_output_tvalid = fill_level != '0;
  assign m_axis_output_tdata  = mem[rd_ptr];
  assign m_axis_output_tlast  = m_axis_output_tvalid && last;
  always_ff @(posedge ap_clk)
    if (push) mem[wr_ptr] <= s_axis_input_tdata;
  // tready is registered from the next fill level, so a pop never frees a slot in the same cycle
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fill_level          <= '0;
      beat_cnt            <= '0;
      block_cnt           <= '0;
      blocks_done         <= '0;
      frame_done          <= 1'b0;
      s_axis_input_tready <= 1'b0;
    end else begin
      frame_done          <= 1'b0;
      fill_level          <= fill_nxt;
      s_axis_input_tready <= fill_nxt < FW'(DEPTH);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        if (last) begin
          blocks_done <= blocks_done + 1'b1;
          block_cnt   <= (block_cnt == SW'(SDIM - 1)) ? '0 : block_cnt + 1'b1;
          frame_done  <= block_cnt == SW'(SDIM - 1);
        end
      end
    end
  end
endmodule
